cache_tag_ctrl_2way: RTL and testbench
======================================

// Module: cache_tag_ctrl_2way
// PURPOSE
//  Tag-lookup and hit-check controller for the 2-way set-associative cache. It drives both sync-read tag RAMs
//  (way 0 = ram_sync_read_t0, way 1 = ram_sync_read_t1) as their only master.
//  Accepts a CPU address request and reports hit/miss plus the way. Keeps a per-set LRU bit.
//  On a miss it allocates the tag into the victim way (write-allocate for reads and writes).
//  After reset it clears every tag entry before it accepts any request.
// PARAMETERS
//  IDX_W  3   set-index width; DEPTH = 1<<IDX_W sets; equals tag RAM AWIDTH
//  TAG_W  13  tag width; tag RAM entry = {valid, tag} = TAG_W+1 bits (tag RAM DWIDTH = 14)
//  OFS_W  2   byte-offset width; ignored for lookup
// PORTS
//  clock       in   1                    single clock; all state changes on rising edge
//  reset_n     in   1                    synchronous, active-low reset
//  req_valid   in   1                    request present
//  req_ready   out  1                    controller can accept; handshake = req_valid & req_ready
//  req_we      in   1                    1 = write access, 0 = read; returned in resp_we
//  req_addr    in   TAG_W+IDX_W+OFS_W    {tag, index, offset}
//  resp_valid  out  1                    one-cycle pulse carrying the result
//  resp_hit    out  1                    1 = hit, 0 = miss (the line is now allocated)
//  resp_way    out  1                    hit way, or the victim way filled on a miss
//  resp_we     out  1                    req_we of the completed request
//  err_multihit out 1                    sticky; set when both ways match the tag
//  t0_addr/t1_addr out IDX_W             tag RAM address (the RAM latches it every edge)
//  t0_din/t1_din   out TAG_W+1           write data {valid, tag}
//  t0_we/t1_we     out 1                 tag RAM write enable
//  t0_dout/t1_dout in  TAG_W+1           tag RAM read data, valid one cycle after the address
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=INIT, init_idx=0, req_ready=0, resp_*=0, err_multihit=0,
//   all LRU bits=0. Reset mid-operation aborts any request; no response is issued for it.
//  INIT: t0_we=t1_we=1, din=0, addr=init_idx; init_idx++ each cycle. The last index goes to IDLE.
//   INIT lasts exactly DEPTH cycles.
//  IDLE: req_ready=1; tN_addr = req_addr index (combinational), we=0. On handshake: latch tag, index and we.
//   Then go to LOOKUP.
//  LOOKUP: req_ready=0; tN_addr = latched index. hitN = doutN[TAG_W] & (doutN[TAG_W-1:0]==tag).
//   Register hit, way, victim and the valid bits. Go to RESP.
//  Way select on hit: hit0 -> way 0, else way 1. If hit0&hit1, pick way 0 and set err_multihit.
//  Victim on miss: invalid way 0 first, then invalid way 1, else lru[index].
//  RESP: resp_valid=1 for this cycle only. On a miss, write {1,tag} to the victim way at the index (single we).
//   LRU update on both hit and miss: lru[index] <= ~way (the bit names the least-recent way).
//   Next state is IDLE. Request-to-response latency = 2 cycles after handshake; throughput 1 request per 3 cycles.
//  req_valid while req_ready=0 is ignored. The requester must hold req_valid and req_addr until the handshake.
//  Never assert t0_we and t1_we together, except in INIT.
//  All outputs are registered, except req_ready, tN_addr, tN_din and tN_we, which are decoded from state.
// STRUCTURE
//  Package cache_pkg: TAG_W/IDX_W/OFS_W defaults, the state enum (INIT, IDLE, LOOKUP, RESP), and the tag-entry field positions.
//  Sub-module cache_lru_2way: DEPTH x 1 LRU bit array.
//   Ports: rd index -> victim bit, plus an update port (index, way used). Cleared on reset.
//  Top level: FSM, the index/tag latch, the comparators, and the tag RAM mux.
// TESTING (bench instantiates two ram_sync_read-style models, IDX_W=3, TAG_W=13)
//  1. Release reset -> req_ready=0 for 8 cycles; all 8 entries of both RAMs read 14'b0; then req_ready=1.
//  2. Read req_addr=18'h00004 (tag 0, index 1) -> resp_valid 2 cycles later; hit=0, way=0.
//     t0[1]={1,13'h0}; lru[1]=1.
//  3. Repeat 18'h00004 -> hit=1, way=0; no tag RAM write; lru[1]=1.
//  4. Write 18'h00024 (tag 1, index 1) -> miss, way=1, t1[1]={1,13'h1}, resp_we=1, lru[1]=0.
//     Then 18'h00044 (tag 2) -> miss, way=0 replaces tag 0; lru[1]=1.
//  5. Preload t0[2]=t1[2]={1,13'h5}, request tag 5 index 2 -> hit=1, way=0, err_multihit=1 until reset.
//  6. Assert reset_n=0 during the LOOKUP cycle -> no resp_valid; INIT reruns for 8 cycles; a previously hit address now misses.

Source files
------------

// File: rtl/cache_tag_ctrl_2way_pkg.sv
// Shared definitions for the 2-way tag controller: default geometry, FSM states
// and the layout of a tag RAM entry ({valid, tag}).
package cache_pkg;

    localparam int CACHE_IDX_W = 3;
    localparam int CACHE_TAG_W = 13;
    localparam int CACHE_OFS_W = 2;

    // Tag field starts at bit 0; the valid flag sits directly above the tag.
    localparam int ENTRY_TAG_LSB = 0;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/cache_tag_ctrl_2way_if.sv
// CPU-side request/response bundle of the tag controller.
interface cache_tag_ctrl_2way_if
    import cache_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int TAG_W = CACHE_TAG_W,
    parameter int OFS_W = CACHE_OFS_W
);
    localparam int ADDR_W = TAG_W + IDX_W + OFS_W;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_way;
    logic              resp_we;
    logic              err_multihit;

    modport master (
        output req_valid, req_we, req_addr,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_we, err_multihit
    );

    modport slave (
        input  req_valid, req_we, req_addr,
        output req_ready, resp_valid, resp_hit, resp_way, resp_we, err_multihit
    );

endinterface

// File: rtl/cache_tag_ctrl_2way_lru.sv
// Per-set replacement state for the 2-way cache: each bit names the
// least-recently-used way of its set.
module cache_lru_2way #(
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             victim,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_way
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] lru_r;

    // after an access the other way becomes the least recent one
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lru_r <= '0;
        end else if (upd_en) begin
            lru_r[upd_idx] <= ~upd_way;
        end else begin
            lru_r <= lru_r;
        end
    end

    assign victim = lru_r[rd_idx];

endmodule

// File: rtl/cache_tag_ctrl_2way.sv
// Tag lookup / hit check for a 2-way set-associative cache; sole master of both
// sync-read tag RAMs, clears them after reset and write-allocates on a miss.
module cache_tag_ctrl_2way
    import cache_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int TAG_W = CACHE_TAG_W,
    parameter int OFS_W = CACHE_OFS_W
) (
    input  logic               clock,
    input  logic               reset_n,
    cache_tag_ctrl_2way_if.slave bus,
    output logic [IDX_W-1:0]   t0_addr,
    output logic [TAG_W:0]     t0_din,
    output logic               t0_we,
    input  logic [TAG_W:0]     t0_dout,
    output logic [IDX_W-1:0]   t1_addr,
    output logic [TAG_W:0]     t1_din,
    output logic               t1_we,
    input  logic [TAG_W:0]     t1_dout
);
    localparam int ADDR_W    = TAG_W + IDX_W + OFS_W;
    localparam int VALID_POS = ENTRY_TAG_LSB + TAG_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDX_W-1:0]  init_idx_r;
    logic [TAG_W-1:0]  tag_r;
    logic [IDX_W-1:0]  idx_r;
    logic              we_r;
    logic              resp_valid_r;
    logic              resp_hit_r;
    logic              resp_way_r;
    logic              resp_we_r;
    logic              err_multihit_r;

    logic              hs_s;
    logic              hit0_s;
    logic              hit1_s;
    logic              way_sel_s;
    logic              lru_victim_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [OFS_W-1:0]  addr_ofs_unused_s;

    assign req_tag_s         = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx_s         = bus.req_addr[OFS_W +: IDX_W];
    assign addr_ofs_unused_s = bus.req_addr[OFS_W-1:0];
    assign hs_s              = bus.req_valid && (state_r == IDLE);

    assign hit0_s = t0_dout[VALID_POS] && (t0_dout[ENTRY_TAG_LSB +: TAG_W] == tag_r);
    assign hit1_s = t1_dout[VALID_POS] && (t1_dout[ENTRY_TAG_LSB +: TAG_W] == tag_r);

    cache_lru_2way #(.IDX_W(IDX_W)) u_lru (
        .clock   (clock),
        .reset_n (reset_n),
        .rd_idx  (idx_r),
        .victim  (lru_victim_s),
        .upd_en  (state_r == RESP),
        .upd_idx (idx_r),
        .upd_way (resp_way_r)
    );

    // hit way wins (way 0 on a double match); otherwise fill an empty way before evicting
    always_comb begin
        way_sel_s = 1'b0;
        if (hit0_s) begin
            way_sel_s = 1'b0;
        end else if (hit1_s) begin
            way_sel_s = 1'b1;
        end else if (!t0_dout[VALID_POS]) begin
            way_sel_s = 1'b0;
        end else if (!t1_dout[VALID_POS]) begin
            way_sel_s = 1'b1;
        end else begin
            way_sel_s = lru_victim_s;
        end
    end

    // state register, request latch and registered response
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r        <= INIT;
            init_idx_r     <= '0;
            tag_r          <= '0;
            idx_r          <= '0;
            we_r           <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_hit_r     <= 1'b0;
            resp_way_r     <= 1'b0;
            resp_we_r      <= 1'b0;
            err_multihit_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            resp_valid_r <= 1'b0;
            case (state_r)
                INIT: begin
                    init_idx_r <= init_idx_r + IDX_W'(1);
                end
                IDLE: begin
                    if (hs_s) begin
                        tag_r <= req_tag_s;
                        idx_r <= req_idx_s;
                        we_r  <= bus.req_we;
                    end
                end
                LOOKUP: begin
                    resp_valid_r <= 1'b1;
                    resp_hit_r   <= hit0_s || hit1_s;
                    resp_way_r   <= way_sel_s;
                    resp_we_r    <= we_r;
                    if (hit0_s && hit1_s) begin
                        err_multihit_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // next state and tag RAM port decode
    always_comb begin
        state_nxt_s = state_r;
        t0_addr     = idx_r;
        t1_addr     = idx_r;
        t0_din      = '0;
        t1_din      = '0;
        t0_we       = 1'b0;
        t1_we       = 1'b0;
        case (state_r)
            INIT: begin
                t0_addr = init_idx_r;
                t1_addr = init_idx_r;
                t0_we   = 1'b1;
                t1_we   = 1'b1;
                if (init_idx_r == LAST_IDX) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            IDLE: begin
                t0_addr = req_idx_s;
                t1_addr = req_idx_s;
                if (hs_s) begin
                    state_nxt_s = LOOKUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOOKUP: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                state_nxt_s = IDLE;
                t0_din      = {1'b1, tag_r};
                t1_din      = {1'b1, tag_r};
                if (!resp_hit_r) begin
                    t0_we = ~resp_way_r;
                    t1_we = resp_way_r;
                end else begin
                    t0_we = 1'b0;
                    t1_we = 1'b0;
                end
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    assign bus.req_ready    = (state_r == IDLE);
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_hit     = resp_hit_r;
    assign bus.resp_way     = resp_way_r;
    assign bus.resp_we      = resp_we_r;
    assign bus.err_multihit = err_multihit_r;

endmodule

// File: tb/tb_cache_tag_ctrl_2way.sv
// Bench for cache_tag_ctrl_2way: two sync-read tag RAM models, a set/way cache
// model compared every cycle, and directed requests with literal expectations.
module tb_cache_tag_ctrl_2way;
    import cache_pkg::*;

    localparam int IW = 3, TW = 13, OW = 2, DEPTH = 8, EW = TW + 1, AW = TW + IW + OW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_tag_ctrl_2way_if #(.IDX_W(IW), .TAG_W(TW), .OFS_W(OW)) bus ();

    logic [IW-1:0] t0_addr, t1_addr;
    logic [EW-1:0] t0_din, t1_din, t0_dout, t1_dout;
    logic          t0_we, t1_we;

    cache_tag_ctrl_2way #(.IDX_W(IW), .TAG_W(TW), .OFS_W(OW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .t0_addr (t0_addr),
        .t0_din  (t0_din),
        .t0_we   (t0_we),
        .t0_dout (t0_dout),
        .t1_addr (t1_addr),
        .t1_din  (t1_din),
        .t1_we   (t1_we),
        .t1_dout (t1_dout)
    );

    // tag RAMs: address latched every edge, data out one cycle later; bench can poison/preload
    logic [EW-1:0] mem0 [DEPTH];
    logic [EW-1:0] mem1 [DEPTH];
    logic [IW-1:0] a0_q, a1_q;
    logic          pl_all = 1'b0;
    logic          pl_en  = 1'b0;
    logic [IW-1:0] pl_idx = '0;
    logic [EW-1:0] pl_val = '0;

    always @(posedge clock) begin
        if (pl_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0[i] <= 14'h3fff;
                mem1[i] <= 14'h2aaa;
            end
        end else if (pl_en) begin
            mem0[pl_idx] <= pl_val;
            mem1[pl_idx] <= pl_val;
        end else begin
            if (t0_we) mem0[t0_addr] <= t0_din;
            if (t1_we) mem1[t1_addr] <= t1_din;
        end
        a0_q <= t0_addr;
        a1_q <= t1_addr;
    end
    assign t0_dout = mem0[a0_q];
    assign t1_dout = mem1[a1_q];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // cache model: valid/tag per set and way, plus the least-recently-used way per set
    bit            mv   [DEPTH][2];
    logic [TW-1:0] mt   [DEPTH][2];
    bit            mlru [DEPTH];

    task automatic model_reset();
        for (int s = 0; s < DEPTH; s++) begin
            mv[s][0] = 1'b0; mv[s][1] = 1'b0;
            mt[s][0] = '0;   mt[s][1] = '0;
            mlru[s]  = 1'b0;
        end
    endtask

    task automatic check_mem(input string name);
        for (int s = 0; s < DEPTH; s++) begin
            chk({name, "_t0"}, 32'(mem0[s]), 32'({mv[s][0], mt[s][0]}));
            chk({name, "_t1"}, 32'(mem1[s]), 32'({mv[s][1], mt[s][1]}));
        end
    endtask

    // expected behaviour tracked per cycle
    bit armed = 1'b0, pend = 1'b0, exp_err = 1'b0;
    bit p_hit, p_way, p_we, p_multi;
    int init_cnt = 0, busy_cnt = 0, pend_cnt = 0;

    always @(negedge clock) begin
        bit e_ready, e_valid, h0, h1, w;
        logic [TW-1:0] tg;
        logic [IW-1:0] ix;
        e_ready = 1'b0;
        e_valid = 1'b0;
        if (armed) begin
            e_ready = (init_cnt == 0) && (busy_cnt == 0);
            e_valid = pend && (pend_cnt == 0);
            if (e_valid && p_multi) exp_err = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_valid));
            chk("err_multihit", 32'(bus.err_multihit), 32'(exp_err));
            if (e_valid) begin
                chk("resp_hit", 32'(bus.resp_hit), 32'(p_hit));
                chk("resp_way", 32'(bus.resp_way), 32'(p_way));
                chk("resp_we", 32'(bus.resp_we), 32'(p_we));
            end
            if (init_cnt == 0) chk("dual_we", 32'(t0_we && t1_we), 32'd0);
        end
        if (pend) begin
            if (pend_cnt == 0) pend = 1'b0;
            else pend_cnt--;
        end
        if (busy_cnt > 0) busy_cnt--;
        if (init_cnt > 0) init_cnt--;
        if (!reset_n) begin
            armed = 1'b1; pend = 1'b0; busy_cnt = 0; init_cnt = DEPTH; exp_err = 1'b0;
            model_reset();
        end else if (armed && e_ready && bus.req_valid) begin
            tg = bus.req_addr[AW-1 -: TW];
            ix = bus.req_addr[OW +: IW];
            h0 = mv[ix][0] && (mt[ix][0] == tg);
            h1 = mv[ix][1] && (mt[ix][1] == tg);
            if (h0)              w = 1'b0;
            else if (h1)         w = 1'b1;
            else if (!mv[ix][0]) w = 1'b0;
            else if (!mv[ix][1]) w = 1'b1;
            else                 w = mlru[ix];
            if (!(h0 || h1)) begin
                mv[ix][w] = 1'b1;
                mt[ix][w] = tg;
            end
            mlru[ix] = ~w;
            p_hit = h0 || h1; p_way = w; p_we = bus.req_we; p_multi = h0 && h1;
            pend = 1'b1; pend_cnt = 1; busy_cnt = 2;
        end
    end

    // issue one request, wait for handshake, check 2-cycle latency, return the response
    task automatic do_req(input logic [AW-1:0] addr, input logic we,
                          output logic hit, output logic way, output logic rwe);
        bit ok;
        @(posedge clock); #1;
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_we = we;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (bus.req_ready) ok = 1'b1;
        end
        chk("handshake_seen", 32'(ok), 32'd1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("lat_cycle1", 32'(bus.resp_valid), 32'd0);
        @(negedge clock);
        chk("lat_cycle2", 32'(bus.resp_valid), 32'd1);
        hit = bus.resp_hit; way = bus.resp_way; rwe = bus.resp_we;
        @(posedge clock); @(negedge clock);
    endtask

    typedef struct { logic [AW-1:0] addr; logic we; logic hit; logic way; } vec_t;

    initial begin
        logic hit, way, rwe;
        int   low_cnt, vcnt;
        vec_t vt [4];
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;

        // 1: poison RAMs under reset, then expect 8 INIT cycles that clear everything
        pl_all = 1'b1;
        repeat (3) @(posedge clock);
        #1; pl_all = 1'b0; reset_n = 1'b1;
        low_cnt = 0;
        for (int k = 0; k < 20 && !bus.req_ready; k++) begin
            @(negedge clock);
            if (!bus.req_ready) low_cnt++;
        end
        chk("init_cycles", 32'(low_cnt), 32'd8);
        for (int s = 0; s < DEPTH; s++) begin
            chk("init_t0", 32'(mem0[s]), 32'd0);
            chk("init_t1", 32'(mem1[s]), 32'd0);
        end

        // 2: cold read miss allocates way 0
        do_req(18'h00004, 1'b0, hit, way, rwe);
        chk("s2_hit", 32'(hit), 32'd0); chk("s2_way", 32'(way), 32'd0); chk("s2_we", 32'(rwe), 32'd0);
        chk("s2_t0_1", 32'(mem0[1]), 32'h2000); chk("s2_t1_1", 32'(mem1[1]), 32'h0000);
        chk("model_lru1", 32'(mlru[1]), 32'd1);

        // 3: repeat hits way 0, no RAM write
        do_req(18'h00004, 1'b0, hit, way, rwe);
        chk("s3_hit", 32'(hit), 32'd1); chk("s3_way", 32'(way), 32'd0);
        chk("s3_t0_1", 32'(mem0[1]), 32'h2000); chk("s3_t1_1", 32'(mem1[1]), 32'h0000);

        // 4: write miss fills empty way 1, then LRU evicts way 0
        do_req(18'h00024, 1'b1, hit, way, rwe);
        chk("s4a_hit", 32'(hit), 32'd0); chk("s4a_way", 32'(way), 32'd1); chk("s4a_we", 32'(rwe), 32'd1);
        chk("s4a_t1_1", 32'(mem1[1]), 32'h2001);
        do_req(18'h00044, 1'b0, hit, way, rwe);
        chk("s4b_hit", 32'(hit), 32'd0); chk("s4b_way", 32'(way), 32'd0);
        chk("s4b_t0_1", 32'(mem0[1]), 32'h2002);
        check_mem("s4_mem");

        // follow-on vectors: way-1 hit, LRU-driven eviction, a different set
        vt[0] = '{18'h00024, 1'b0, 1'b1, 1'b1};
        vt[1] = '{18'h00064, 1'b1, 1'b0, 1'b0};
        vt[2] = '{18'h00044, 1'b0, 1'b0, 1'b1};
        vt[3] = '{18'h3fffc, 1'b1, 1'b0, 1'b0};
        vcnt = 0;
        foreach (vt[i]) begin
            do_req(vt[i].addr, vt[i].we, hit, way, rwe);
            chk("vec_hit", 32'(hit), 32'(vt[i].hit));
            chk("vec_way", 32'(way), 32'(vt[i].way));
            chk("vec_we", 32'(rwe), 32'(vt[i].we));
            vcnt++;
        end
        check_mem("vec_mem");

        // 5: same tag in both ways -> way 0 and sticky error
        @(posedge clock); #1;
        pl_en = 1'b1; pl_idx = 3'd2; pl_val = {1'b1, 13'h5};
        @(posedge clock); #1;
        pl_en = 1'b0;
        mv[2][0] = 1'b1; mv[2][1] = 1'b1; mt[2][0] = 13'h5; mt[2][1] = 13'h5;
        do_req(18'h000a8, 1'b0, hit, way, rwe);
        chk("s5_hit", 32'(hit), 32'd1); chk("s5_way", 32'(way), 32'd0);
        repeat (4) @(negedge clock);
        chk("s5_err_sticky", 32'(bus.err_multihit), 32'd1);

        // 6: reset during LOOKUP -> no response, INIT again, old hit now misses
        @(posedge clock); #1;
        bus.req_valid = 1'b1; bus.req_addr = 18'h00044; bus.req_we = 1'b0;
        @(negedge clock);
        chk("s6_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0; reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1;
        low_cnt = 0;
        for (int k = 0; k < 20 && !bus.req_ready; k++) begin
            @(negedge clock);
            if (bus.resp_valid) chk("s6_no_resp", 32'd1, 32'd0);
            if (!bus.req_ready) low_cnt++;
        end
        chk("s6_init_cycles", 32'(low_cnt), 32'd8);
        chk("s6_err_clear", 32'(bus.err_multihit), 32'd0);
        do_req(18'h00044, 1'b0, hit, way, rwe);
        chk("s6_hit", 32'(hit), 32'd0); chk("s6_way", 32'(way), 32'd0);
        check_mem("s6_mem");

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
